// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of instr_loader.
// master = loader side, slave = stream source / memory side.
interface instr_loader_if;
  // Handshake: a byte transfers on a clk edge where in_valid & in_ready are both 1.
  // The sender holds in_data/in_valid stable until that edge; in_ready never depends on in_valid.
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_w_en;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_w_en, mem_w_addr, mem_w_data
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_w_en, mem_w_addr, mem_w_data
  );
endinterface

// File: rtl/instr_loader.sv
// Loads a length-prefixed little-endian program image into instruction memory and
// holds the core in reset until it is accepted. Optional trailing checksum: LOADER_CSUM_EN.
module instr_loader #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          ADDR_STEP = 4,
  parameter bit          BOOT_HOLD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_loader_if.master        bus,
  input  logic                  load_req,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           words_done,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [16:0] MAX_N      = 17'(MEM_WORDS);
  localparam logic [31:0] STEP       = 32'(ADDR_STEP);
  localparam state_t      RESET_STATE = BOOT_HOLD ? S_LEN_LO : S_IDLE;
`ifdef LOADER_CSUM_EN
  localparam state_t      S_FINISH   = S_CSUM;
`else
  localparam state_t      S_FINISH   = S_DONE;
`endif

  state_t      state, state_next;
  logic        xfer;
  logic [15:0] len_in;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic [7:0]  csum;
  logic        w_en_q;
  logic [31:0] w_addr_q;
  logic [31:0] w_data_q;

  assign bus.in_ready   = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                          (state == S_DATA)   || (state == S_CSUM);
  assign xfer           = bus.in_valid && bus.in_ready;
  assign len_in         = {bus.in_data, len_lo};
  assign bus.mem_w_en   = w_en_q;
  assign bus.mem_w_addr = w_addr_q;
  assign bus.mem_w_data = w_data_q;
  assign busy           = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA) ||
                          (state == S_WRITE)  || (state == S_CSUM);
  assign err            = (state == S_ERR);
  assign state_dbg      = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (load_req) state_next = S_LEN_LO;
      S_LEN_LO: if (xfer) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if ({1'b0, len_in} > MAX_N) state_next = S_ERR;
          else if (len_in == 16'd0)   state_next = S_FINISH;
          else                        state_next = S_DATA;
        end
      end
      S_DATA: if (xfer && byte_cnt == 2'd3) state_next = S_WRITE;
      // words_done still holds the pre-increment count during WRITE
      S_WRITE: state_next = (words_done + 16'd1 != len) ? S_DATA : S_FINISH;
`ifdef LOADER_CSUM_EN
      S_CSUM: if (xfer) state_next = (bus.in_data == csum) ? S_DONE : S_ERR;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_en_q     <= 1'b0;
      w_addr_q   <= BASE_ADDR;
      w_data_q   <= 32'h0;
      words_done <= 16'h0;
      byte_cnt   <= 2'd0;
      asm_word   <= 32'h0;
      len_lo     <= 8'h0;
      len        <= 16'h0;
      csum       <= 8'h0;
      core_rst_n <= !BOOT_HOLD;
    end else begin
      w_en_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (load_req) begin
            core_rst_n <= 1'b0;
            words_done <= 16'h0;
            w_addr_q   <= BASE_ADDR;
            byte_cnt   <= 2'd0;
            csum       <= 8'h0;
          end
        end
        S_LEN_LO: if (xfer) len_lo <= bus.in_data;
        S_LEN_HI: if (xfer) len <= len_in;
        S_DATA: begin
          if (xfer) begin
            asm_word <= {bus.in_data, asm_word[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            csum     <= csum + bus.in_data;
            if (byte_cnt == 2'd3) begin
              w_en_q   <= 1'b1;
              w_data_q <= {bus.in_data, asm_word[31:8]};
            end
          end
        end
        S_WRITE: begin
          w_addr_q   <= w_addr_q + STEP;
          words_done <= words_done + 16'd1;
        end
        default: ;
      endcase
      if (state_next == S_DONE && state != S_DONE) core_rst_n <= 1'b1;
      if (state_next == S_ERR) core_rst_n <= 1'b0;
    end
  end

endmodule
